// File: rtl/fpu_mc.sv
// fpu_mc: multi-cycle IEEE-754 binary FPU (add, sub, mul, div), round-to-nearest-even.
// Holds one operation in flight. Denormals are flushed to zero on input and output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands/op valid          in_ready   can accept (only in IDLE)
//   a, b       operands (W = 1+EXP_W+MAN_W bits)
//   op         00 add, 01 sub (a-b), 10 mul, 11 div (a/b)
//   out_valid  result/flags valid         out_ready  consumer accepts result
//   result     IEEE result
//   flags      {invalid, div_by_zero, overflow, underflow, inexact}
//
// Pipeline of states: IDLE -> UNPACK -> EXEC -> NORM -> ROUND -> DONE.
// Every operation produces a value in 'acc' plus an exponent 're' such that the
// MSB of acc carries weight 2^re (biased). NORM then left-justifies acc and
// ROUND extracts significand/guard/sticky, so the back end is shared by all ops.
module fpu_mc #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int M     = MAN_W + 1;          // significand incl. hidden bit
    localparam int WW    = 2 * M;              // working accumulator width
    localparam int EW    = EXP_W + 3;          // signed working exponent width
    localparam int DIV_N = MAN_W + 3;          // quotient bits, one per EXEC cycle
    localparam int CW    = $clog2(DIV_N + 1);
    localparam logic [EXP_W-1:0] EMAX      = '1;
    localparam logic [EW-1:0]    BIAS      = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0] SHIFT_SAT = EXP_W'(MAN_W + 3);
    localparam logic [1:0] OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, EXEC, NORM, ROUND, DONE} state_t;
    state_t state;

    logic [W-1:0]  a_q, b_q;
    logic [1:0]    op_q;
    logic          spec;
    logic [W-1:0]  spec_res;
    logic [4:0]    spec_flg;
    logic          rs, stk;
    logic [EW-1:0] re;
    logic [WW-1:0] acc;
    logic [M:0]    rem;
    logic [CW-1:0] cnt;

    // ---------------- operand decode ----------------
    logic [EXP_W-1:0] ax, bx;
    logic [M-1:0]     ma, mb;
    logic             sa, sb, sx;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

    always_comb begin
        ax     = a_q[MAN_W +: EXP_W];
        bx     = b_q[MAN_W +: EXP_W];
        a_zero = (ax == '0);               // denormals flush to zero
        b_zero = (bx == '0);
        a_inf  = (ax == EMAX) && (a_q[MAN_W-1:0] == '0);
        b_inf  = (bx == EMAX) && (b_q[MAN_W-1:0] == '0);
        a_nan  = (ax == EMAX) && (a_q[MAN_W-1:0] != '0);
        b_nan  = (bx == EMAX) && (b_q[MAN_W-1:0] != '0);
        a_snan = a_nan && !a_q[MAN_W-1];
        b_snan = b_nan && !b_q[MAN_W-1];
        ma     = a_zero ? '0 : {1'b1, a_q[MAN_W-1:0]};
        mb     = b_zero ? '0 : {1'b1, b_q[MAN_W-1:0]};
        sa     = a_q[W-1];
        sb     = b_q[W-1] ^ (op_q == OP_SUB);   // effective sign of b
        sx     = a_q[W-1] ^ b_q[W-1];
    end

    // ---------------- special-case resolution ----------------
    logic         sp;
    logic [W-1:0] sp_res;
    logic [4:0]   sp_flg;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sp     = 1'b1;
        sp_res = QNAN;
        sp_flg = '0;
        if (a_nan || b_nan) begin
            sp_flg[4] = a_snan || b_snan;
        end else if (op_q == OP_MUL) begin
            if ((a_inf && b_zero) || (a_zero && b_inf)) sp_flg[4] = 1'b1;
            else if (a_inf || b_inf)                    sp_res = {sx, EMAX, {MAN_W{1'b0}}};
            else if (a_zero || b_zero)                  sp_res = {sx, {(W-1){1'b0}}};
            else                                        sp = 1'b0;
        end else if (op_q == OP_DIV) begin
            if ((a_zero && b_zero) || (a_inf && b_inf)) sp_flg[4] = 1'b1;
            else if (a_inf)  sp_res = {sx, EMAX, {MAN_W{1'b0}}};
            else if (b_inf)  sp_res = {sx, {(W-1){1'b0}}};
            else if (b_zero) begin
                sp_res    = {sx, EMAX, {MAN_W{1'b0}}};
                sp_flg[3] = 1'b1;
            end
            else if (a_zero) sp_res = {sx, {(W-1){1'b0}}};
            else             sp = 1'b0;
        end else begin
            if (a_inf && b_inf) begin
                if (sa != sb) sp_flg[4] = 1'b1;
                else          sp_res = {sa, EMAX, {MAN_W{1'b0}}};
            end
            else if (a_inf) sp_res = {sa, EMAX, {MAN_W{1'b0}}};
            else if (b_inf) sp_res = {sb, EMAX, {MAN_W{1'b0}}};
            else            sp = 1'b0;
        end
    end

    // ---------------- EXEC datapaths ----------------
    logic             a_big, add_s, q_bit;
    logic [EXP_W-1:0] big_e, dexp, dsat;
    logic [M-1:0]     big_m, sml_m;
    logic [M+2:0]     sh_in, aligned;    // significand + guard/round/sticky
    logic [M+3:0]     sum;
    logic [WW-1:0]    prod;
    logic [M:0]       rem_nxt;

    always_comb begin
        a_big   = {ax, ma} >= {bx, mb};
        big_e   = a_big ? ax : bx;
        big_m   = a_big ? ma : mb;
        sml_m   = a_big ? mb : ma;
        dexp    = a_big ? ax - bx : bx - ax;
        dsat    = (dexp > SHIFT_SAT) ? SHIFT_SAT : dexp;
        sh_in   = {sml_m, 3'b000};
        // bits shifted past the sticky position collapse into bit 0
        aligned = (sh_in >> dsat) |
                  {{(M+2){1'b0}}, |(sh_in & ~({(M+3){1'b1}} << dsat))};
        sum     = (sa ^ sb) ? {1'b0, big_m, 3'b000} - {1'b0, aligned}
                            : {1'b0, big_m, 3'b000} + {1'b0, aligned};
        // exact zero is +0 unless both addends are -0
        add_s   = (sum == '0) ? (sa & sb) : (a_big ? sa : sb);
        prod    = {{M{1'b0}}, ma} * {{M{1'b0}}, mb};
        // restoring division step
        q_bit   = rem >= {1'b0, mb};
        rem_nxt = (q_bit ? rem - {1'b0, mb} : rem) << 1;
    end

    // ---------------- normalise / round ----------------
    logic [EW-1:0] lz, er;
    logic [M-1:0]  mant;
    logic [M:0]    mr;
    logic          g, st, up;
    logic [W-1:0]  rnd_res;
    logic [4:0]    rnd_flg;

    always_comb begin
        lz = EW'(WW);
        for (int i = 0; i < WW; i++) begin
            if (acc[i]) lz = EW'(WW - 1 - i);
        end
        mant = acc[WW-1 -: M];
        g    = acc[WW-1-M];
        st   = stk | (|acc[WW-2-M:0]);
        up   = g & (st | mant[0]);
        mr   = {1'b0, mant} + {{M{1'b0}}, up};
        er   = re + {{(EW-1){1'b0}}, mr[M]};    // rounding carry bumps the exponent
        if (acc == '0) begin
            rnd_res = {rs, {(W-1){1'b0}}};
            rnd_flg = '0;
        end else if ($signed(er) >= $signed({3'b000, EMAX})) begin
            rnd_res = {rs, EMAX, {MAN_W{1'b0}}};
            rnd_flg = 5'b00101;
        end else if ($signed(er) <= 0) begin
            rnd_res = {rs, {(W-1){1'b0}}};
            rnd_flg = 5'b00011;
        end else begin
            rnd_res = {rs, er[EXP_W-1:0], mr[MAN_W-1:0]};
            rnd_flg = {4'b0000, g | st};
        end
    end

    // ---------------- control FSM ----------------
    // NOTE: only control state and outputs are reset; datapath registers are always
    // written before they are read, so they carry no reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= a;
                    b_q      <= b;
                    op_q     <= op;
                    in_ready <= 1'b0;
                    state    <= UNPACK;
                end
                UNPACK: begin
                    spec     <= sp;
                    spec_res <= sp_res;
                    spec_flg <= sp_flg;
                    rem      <= {1'b0, ma};
                    acc      <= '0;
                    stk      <= 1'b0;
                    cnt      <= '0;
                    state    <= EXEC;
                end
                EXEC: begin
                    if (op_q == OP_DIV) begin
                        // quotient fills acc from the bottom; first bit has weight 2^0
                        acc <= {acc[WW-2:0], q_bit};
                        rem <= rem_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(DIV_N - 1)) begin
                            stk   <= (rem_nxt != '0);
                            rs    <= sx;
                            re    <= EW'(ax) - EW'(bx) + BIAS + EW'(WW - DIV_N);
                            state <= NORM;
                        end
                    end else if (op_q == OP_MUL) begin
                        acc   <= prod;
                        rs    <= sx;
                        re    <= EW'(ax) + EW'(bx) - BIAS + EW'(1);
                        state <= NORM;
                    end else begin
                        acc   <= WW'(sum);
                        rs    <= add_s;
                        re    <= EW'(big_e) + EW'(WW - M - 3);
                        state <= NORM;
                    end
                end
                NORM: begin
                    acc   <= acc << lz;
                    re    <= re - lz;
                    state <= ROUND;
                end
                ROUND: begin
                    result    <= spec ? spec_res : rnd_res;
                    flags     <= spec ? spec_flg : rnd_flg;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_mc.sv
// Scoreboard bench for fpu_mc: binary32 instance plus a binary16 instance.
module tb_fpu_mc;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [1:0]  op;
    logic [4:0]  flags;
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, result16;
    logic [1:0]  op16;
    logic [4:0]  flags16;

    fpu_mc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fpu_mc #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .flags(flags16)
    );

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q32[$], q16[$];
    exp_t cur32, cur16;
    bit   seen32 = 1'b0, seen16 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // monitors: pop on the first cycle of out_valid, re-check at the handshake
    always @(negedge clk) begin
        if (out_valid && !seen32) begin
            if (q32.size() == 0) check("unexpected_out32", 32'(out_valid), 32'd0);
            else begin
                cur32  = q32.pop_front();
                seen32 = 1'b1;
                check("lat32", 32'(cyc - cur32.acc), 32'(cur32.lat));
                check("res32", result, cur32.res);
                check("flg32", 32'(flags), 32'(cur32.flg));
            end
        end
        if (out_valid && out_ready && seen32) begin
            check("hold_res32", result, cur32.res);
            check("hold_flg32", 32'(flags), 32'(cur32.flg));
            seen32 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (out_valid16 && !seen16) begin
            if (q16.size() == 0) check("unexpected_out16", 32'(out_valid16), 32'd0);
            else begin
                cur16  = q16.pop_front();
                seen16 = 1'b1;
                check("lat16", 32'(cyc - cur16.acc), 32'(cur16.lat));
                check("res16", 32'(result16), cur16.res);
                check("flg16", 32'(flags16), 32'(cur16.flg));
            end
        end
        if (out_valid16 && out_ready16 && seen16) seen16 = 1'b0;
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                         input logic [31:0] er, input logic [4:0] ef, input int lat, input bit push);
        int   n = 0;
        exp_t e;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) check("issue_timeout32", 32'(in_ready), 32'd1);
        a = ia; b = ib; op = iop; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.res = er; e.flg = ef; e.lat = lat; e.acc = cyc;
        if (push) q32.push_back(e);
    endtask

    task automatic issue16(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] iop,
                           input logic [15:0] er, input int lat);
        int   n = 0;
        exp_t e;
        while (!in_ready16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) check("issue_timeout16", 32'(in_ready16), 32'd1);
        a16 = ia; b16 = ib; op16 = iop; in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        e.res = 32'(er); e.flg = 5'd0; e.lat = lat; e.acc = cyc;
        q16.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0 || seen32 || seen16) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n == 500) check("drain_timeout", 32'(q32.size() + q16.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int ov;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = ADD;
        in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; op16 = ADD;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed vectors: a, b, op, expected result, expected flags, latency
        issue(32'h40A00000, 32'h40000000, SUB, 32'h40400000, 5'b00000, 4,  1'b1);
        issue(32'h40800000, 32'h40000000, DIV, 32'h40000000, 5'b00000, 29, 1'b1);
        issue(32'h3F800000, 32'h00000000, DIV, 32'h7F800000, 5'b01000, 29, 1'b1);
        issue(32'h7F800000, 32'hFF800000, ADD, 32'h7FC00000, 5'b10000, 4,  1'b1);
        issue(32'h7FC00000, 32'h3F800000, SUB, 32'h7FC00000, 5'b00000, 4,  1'b1);
        issue(32'h00000001, 32'h3F800000, MUL, 32'h00000000, 5'b00000, 4,  1'b1);
        issue(32'h7F7FFFFF, 32'h40000000, MUL, 32'h7F800000, 5'b00101, 4,  1'b1);
        issue(32'h3FC00000, 32'h40200000, MUL, 32'h40700000, 5'b00000, 4,  1'b1);
        issue(32'h3F800000, 32'h40400000, DIV, 32'h3EAAAAAB, 5'b00001, 29, 1'b1);
        issue(32'h3F800000, 32'hBF800000, ADD, 32'h00000000, 5'b00000, 4,  1'b1);
        issue(32'h80000000, 32'h80000000, ADD, 32'h80000000, 5'b00000, 4,  1'b1);
        issue(32'h7F800001, 32'h3F800000, MUL, 32'h7FC00000, 5'b10000, 4,  1'b1);
        issue(32'h00800000, 32'h3F000000, MUL, 32'h00000000, 5'b00011, 4,  1'b1);
        issue(32'h40000000, 32'hFF800000, DIV, 32'h80000000, 5'b00000, 29, 1'b1);
        issue(32'h3F800000, 32'h33800000, ADD, 32'h3F800000, 5'b00001, 4,  1'b1);
        drain();

        // backpressure: hold DONE for 6 cycles with a stray request in the middle
        out_ready = 1'b0;
        issue(32'h3F800000, 32'h3F800000, ADD, 32'h40000000, 5'b00000, 4, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                a = 32'h40400000; b = 32'h40400000; op = MUL; in_valid = 1'b1;
            end
            if (i == 3) in_valid = 1'b0;
            @(negedge clk);
            check("bp_result", result, 32'h40000000);
            check("bp_flags", 32'(flags), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        drain();

        // reset in the middle of a divide: the result must never appear
        issue(32'h40800000, 32'h40000000, DIV, 32'h0, 5'b0, 0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        ov = 0;
        repeat (40) begin
            @(negedge clk);
            ov += int'(out_valid);
        end
        check("midrst_no_output", 32'(ov), 32'd0);

        // binary16 instance
        issue16(16'h4500, 16'h4000, SUB, 16'h4200, 4);
        issue16(16'h4400, 16'h4000, DIV, 16'h4000, 16);
        issue16(16'h3E00, 16'h4100, MUL, 16'h4380, 4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
